wsp_sequencer: RTL and testbench

Wrapper serial port sequencer for the IEEE 1500 wrapper. It accepts one scan command at a time from a host-side controller and drives the wrapper serial control signals for that command: SelectWIR, CaptureWR, ShiftWR and UpdateWR. It serialises the command payload onto WSI and deserialises WSO into a response word. It sits between the test access controller and the wrapper instruction/boundary register logic, and is the only driver of those strobes.

---
 rtl/wsp_pkg.sv | 24 ++
 rtl/wsp_sequencer.sv | 179 +++++++++++++++++
 tb/tb_wsp_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wsp_pkg.sv
// Shared definitions for the IEEE 1500 wrapper serial port sequencer:
// FSM states, command op codes and the host-visible WIR opcodes.
package wsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } wsp_state_e;

    localparam logic OP_SCAN_WDR = 1'b0;
    localparam logic OP_LOAD_WIR = 1'b1;

    localparam int unsigned WIR_W = 12;

    // One-hot WIR instruction fields loaded by the host through OP_LOAD_WIR.
    localparam logic [WIR_W-1:0] WIR_BYPASS = 12'h001;
    localparam logic [WIR_W-1:0] WIR_EXTEST = 12'h002;
    localparam logic [WIR_W-1:0] WIR_SAFE   = 12'h004;
    localparam logic [WIR_W-1:0] WIR_INTEST = 12'h008;

endpackage

// File: rtl/wsp_sequencer.sv
// Wrapper serial port sequencer: runs one CAPTURE/SHIFT/UPDATE command at a time,
// serialising the payload onto WSI and collecting WSO into a right-justified response.
module wsp_sequencer
    import wsp_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int WIR_LEN = 12
) (
    input  logic               WRCK,
    input  logic               WRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic               cmd_noupd,
    input  logic               abort,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               SelectWIR,
    output logic               CaptureWR,
    output logic               ShiftWR,
    output logic               UpdateWR,
    output logic               WSI,
    input  logic               WSO
);

    wsp_state_e         state_q, state_d;
    logic               op_q, op_d;
    logic               noupd_q, noupd_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   k_q, k_d;
    logic [MAX_LEN-1:0] shreg_q, shreg_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic               sel_q, sel_d;
    logic               capwr_q, capwr_d;
    logic               shwr_q, shwr_d;
    logic               updwr_q, updwr_d;
    logic               wsi_q, wsi_d;
    logic               abort_hit_s;

    function automatic logic [LEN_W-1:0] eff_len(input logic op, input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] l;
        if (op == OP_LOAD_WIR) begin
            l = LEN_W'(WIR_LEN);
        end else if (len > LEN_W'(MAX_LEN)) begin
            l = LEN_W'(MAX_LEN);
        end else begin
            l = len;
        end
        return l;
    endfunction

    // Next-state logic; every output strobe is derived from the next state so it leaves a flop.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        noupd_d     = noupd_q;
        len_d       = len_q;
        k_d         = k_q;
        shreg_d     = shreg_q;
        cap_d       = cap_q;
        abort_hit_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    noupd_d = cmd_noupd;
                    len_d   = eff_len(cmd_op, cmd_len);
                    shreg_d = cmd_data;
                    cap_d   = {MAX_LEN{1'b0}};
                    k_d     = {LEN_W{1'b0}};
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                k_d = {LEN_W{1'b0}};
                if (abort) begin
                    abort_hit_s = 1'b1;
                    state_d     = ST_DONE;
                end else if (len_q != {LEN_W{1'b0}}) begin
                    state_d = ST_SHIFT;
                end else if (noupd_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_SHIFT: begin
                // The bit on the abort edge is still captured, so an abort in shift n keeps n bits.
                cap_d   = cap_q | (MAX_LEN'(WSO) << k_q);
                shreg_d = shreg_q >> 1;
                k_d     = k_q + LEN_W'(1);
                if (abort) begin
                    abort_hit_s = 1'b1;
                    state_d     = ST_DONE;
                end else if (k_q == (len_q - LEN_W'(1))) begin
                    state_d = noupd_q ? ST_DONE : ST_UPDATE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_UPDATE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        rsp_err_d   = abort_hit_s;
        capwr_d     = (state_d == ST_CAPTURE);
        shwr_d      = (state_d == ST_SHIFT);
        updwr_d     = (state_d == ST_UPDATE);
        sel_d       = (capwr_d | shwr_d | updwr_d) & op_d;
        wsi_d       = shwr_d & shreg_d[0];
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge WRCK or posedge WRST) begin
        if (WRST) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            noupd_q     <= 1'b0;
            len_q       <= {LEN_W{1'b0}};
            k_q         <= {LEN_W{1'b0}};
            shreg_q     <= {MAX_LEN{1'b0}};
            cap_q       <= {MAX_LEN{1'b0}};
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            sel_q       <= 1'b0;
            capwr_q     <= 1'b0;
            shwr_q      <= 1'b0;
            updwr_q     <= 1'b0;
            wsi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            noupd_q     <= noupd_d;
            len_q       <= len_d;
            k_q         <= k_d;
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            sel_q       <= sel_d;
            capwr_q     <= capwr_d;
            shwr_q      <= shwr_d;
            updwr_q     <= updwr_d;
            wsi_q       <= wsi_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = cap_q;
    assign SelectWIR = sel_q;
    assign CaptureWR = capwr_q;
    assign ShiftWR   = shwr_q;
    assign UpdateWR  = updwr_q;
    assign WSI       = wsi_q;

endmodule

// File: tb/tb_wsp_sequencer.sv
// Scoreboard bench for wsp_sequencer: the driver pushes expected responses computed
// from the command rules, and a negedge monitor checks strobes and responses.
module tb_wsp_sequencer;
    import wsp_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int WIR_LEN = 12;

    logic               WRCK = 1'b0;
    logic               WRST = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_op = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               cmd_noupd = 1'b0;
    logic               abort = 1'b0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI;
    logic               loop_mode = 1'b0;
    logic               wso_drv = 1'b0;
    logic               quiet = 1'b0;
    logic               wso_s;

    assign wso_s = loop_mode ? WSI : wso_drv;

    wsp_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .WIR_LEN(WIR_LEN)) dut (
        .WRCK(WRCK), .WRST(WRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_noupd(cmd_noupd),
        .abort(abort),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .SelectWIR(SelectWIR), .CaptureWR(CaptureWR), .ShiftWR(ShiftWR),
        .UpdateWR(UpdateWR), .WSI(WSI), .WSO(wso_s)
    );

    always #5 WRCK = ~WRCK;

    int cyc = 0;
    always @(posedge WRCK) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic        op;
        logic [31:0] data;
        logic [31:0] wsi;
        logic        err;
        int          cyc;
        int          ncap;
        int          nsh;
        int          nupd;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mask_n(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_strobes"}, 32'({SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI}), 32'd0);
        chk({tag, "_rsp"}, 32'({rsp_valid, rsp_err}), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    endtask

    // Monitor: protocol checks every cycle, scoreboard pop on each response.
    int          m_cap = 0, m_sh = 0, m_upd = 0, m_selbad = 0;
    logic [31:0] m_wsi = '0;
    logic [31:0] last_rsp = '0;
    logic        stab = 1'b1;
    exp_t        m_e;

    initial begin
        forever begin
            @(negedge WRCK);
            if (WRST) begin
                m_cap = 0; m_sh = 0; m_upd = 0; m_selbad = 0; m_wsi = '0;
                last_rsp = '0; stab = 1'b1;
            end else begin
                chk("strobe_onehot", 32'($countones({CaptureWR, ShiftWR, UpdateWR}) <= 1), 32'd1);
                if (!ShiftWR) chk("wsi_outside_shift", 32'(WSI), 32'd0);
                if (!(CaptureWR | ShiftWR | UpdateWR)) chk("selwir_idle", 32'(SelectWIR), 32'd0);
                if (stab && cmd_ready) chk("rsp_data_stable", rsp_data, last_rsp);
                if (CaptureWR) stab = 1'b0;
                if (!quiet && (CaptureWR | ShiftWR | UpdateWR)) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_strobe", 32'd1, 32'd0);
                    end else if (SelectWIR !== exp_q[0].op) begin
                        m_selbad++;
                    end
                    if (ShiftWR) begin
                        m_wsi = m_wsi | ({31'd0, WSI} << m_sh);
                        m_sh++;
                    end
                    if (CaptureWR) m_cap++;
                    if (UpdateWR) m_upd++;
                end
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rsp", 32'd1, 32'd0);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk("rsp_data", rsp_data, m_e.data);
                        chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
                        chk("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
                        chk("n_capture", 32'(m_cap), 32'(m_e.ncap));
                        chk("n_shift", 32'(m_sh), 32'(m_e.nsh));
                        chk("n_update", 32'(m_upd), 32'(m_e.nupd));
                        chk("wsi_bits", m_wsi, m_e.wsi);
                        chk("selwir_mismatch_cycles", 32'(m_selbad), 32'd0);
                    end
                    m_cap = 0; m_sh = 0; m_upd = 0; m_selbad = 0; m_wsi = '0;
                    last_rsp = rsp_data;
                    stab = 1'b1;
                end
            end
        end
    end

    // Issue one command, push its expected outcome, then scramble inputs while it runs.
    task automatic run_cmd(input logic op, input int len, input logic [31:0] data,
                           input logic noupd, input int abort_at, input logic lp,
                           input logic [31:0] vec, input logic hold, input logic btb);
        int   L, shifts, A, R, waits, k;
        logic aborted;
        exp_t e;
        L       = (op == OP_LOAD_WIR) ? WIR_LEN : ((len > MAX_LEN) ? MAX_LEN : len);
        aborted = (abort_at >= 0) && (abort_at <= L);
        shifts  = aborted ? abort_at : L;
        @(negedge WRCK);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_data = data;
        cmd_noupd = noupd; abort = 1'b0; loop_mode = lp; wso_drv = 1'($urandom);
        waits = 0;
        while (!cmd_ready && waits < 100) begin
            @(negedge WRCK);
            waits++;
        end
        if (waits >= 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        if (btb) chk("btb_accept_wait", 32'(waits), 32'd0);
        A = cyc + 1;
        R = aborted ? (A + abort_at + 1) : (A + L + 1 + (noupd ? 0 : 1));
        e.op   = op;
        e.data = (lp ? data : vec) & mask_n(shifts);
        e.wsi  = data & mask_n(shifts);
        e.err  = aborted;
        e.cyc  = R;
        e.ncap = 1;
        e.nsh  = shifts;
        e.nupd = (aborted || noupd) ? 0 : 1;
        exp_q.push_back(e);
        for (int p = A; p <= R; p++) begin
            @(negedge WRCK);
            chk("ready_low_busy", 32'(cmd_ready), 32'd0);
            cmd_valid = hold ? 1'b1 : 1'($urandom);
            cmd_op    = 1'($urandom);
            cmd_len   = LEN_W'($urandom);
            cmd_data  = $urandom;
            cmd_noupd = 1'($urandom);
            k = p - A - 1;
            wso_drv = (k >= 0 && k < 32) ? vec[k] : 1'($urandom);
            abort   = (p == A + abort_at);
        end
        cmd_valid = hold;
        abort     = 1'b0;
    endtask

    initial begin
        int   len, ab;
        logic op;
        repeat (3) @(negedge WRCK);
        check_quiet_outputs("in_reset");
        WRST = 1'b0;
        repeat (3) @(negedge WRCK);
        check_quiet_outputs("idle");

        // Reset during SHIFT of an L=8 scan: strobes vanish at once, no response follows.
        quiet = 1'b1;
        cmd_valid = 1'b1; cmd_op = OP_SCAN_WDR; cmd_len = 6'd8; cmd_data = $urandom; cmd_noupd = 1'b0;
        @(posedge WRCK);
        #1 cmd_valid = 1'b0;
        repeat (2) @(posedge WRCK);
        #2;
        chk("shift_before_reset", 32'(ShiftWR), 32'd1);
        WRST = 1'b1;
        #1;
        chk("async_reset_strobes", 32'({SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, rsp_valid}), 32'd0);
        quiet = 1'b0;
        repeat (2) @(negedge WRCK);
        WRST = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge WRCK);
            chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        end

        run_cmd(OP_LOAD_WIR, 5, 32'h0000_0A5C, 1'b0, -1, 1'b1, 32'd0, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 0, $urandom, 1'b0, -1, 1'b0, $urandom, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 40, $urandom, 1'b0, -1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 16, $urandom, 1'b0, 5, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 4, $urandom, 1'b0, -1, 1'b0, $urandom, 1'b1, 1'b0);
        run_cmd(OP_SCAN_WDR, 4, $urandom, 1'b0, -1, 1'b0, $urandom, 1'b0, 1'b1);
        run_cmd(OP_LOAD_WIR, 0, 32'(WIR_EXTEST), 1'b1, -1, 1'b1, 32'd0, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 10, $urandom, 1'b0, 0, 1'b0, $urandom, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 6, $urandom, 1'b0, 7, 1'b0, $urandom, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 0, $urandom, 1'b1, -1, 1'b0, $urandom, 1'b0, 1'b0);
        run_cmd(OP_SCAN_WDR, 32, $urandom, 1'b1, 32, 1'b0, $urandom, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op  = 1'($urandom);
            len = int'($urandom_range(0, 40));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 34)) : -1;
            run_cmd(op, len, $urandom, 1'($urandom), ab, 1'($urandom), $urandom, 1'b0, 1'b0);
        end

        @(negedge WRCK);
        cmd_valid = 1'b0;
        repeat (5) @(negedge WRCK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
